// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU writeback stage: EX->WB payload, RF write port,
// optional EX forwarding bundle, queued entry and the WB state encoding.
package fir_xifu_pkg;

  localparam int unsigned NB_REGS = 4;
  localparam int unsigned RD_W    = $clog2(NB_REGS);
  localparam int unsigned ID_W    = 4;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [RD_W-1:0] rd;
    logic            write;
    logic [4:0]      core_rd;
    logic            core_we;
    logic [31:0]     result;
  } fir_xifu_ex2wb_t;

  typedef struct packed {
    logic            write;
    logic [RD_W-1:0] rd;
    logic [31:0]     result;
  } fir_xifu_wb2regfile_t;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic [31:0]     result;
  } fir_xifu_wb2ex_fwd_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [RD_W-1:0] rd;
    logic            write;
    logic [4:0]      core_rd;
    logic            core_we;
    logic [31:0]     result;
  } fir_xifu_wb_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT_COMMIT,
    WB_RESULT
  } fir_xifu_wb_state_e;

endpackage

// File: rtl/fir_xifu_wb_fifo.sv
// In-order result queue for the WB stage. DEPTH must be a power of two so the
// pointers wrap naturally; the extra count bit separates full from empty.
module fir_xifu_wb_fifo #(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = logic [7:0]
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output logic   last_o,
  output entry_t head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign last_o  = (r_count == CNT_W'(1));
  assign head_o  = r_mem[r_rd_ptr];

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fir_xifu_wb.sv
// FIR XIFU writeback: queues EX results, waits for commit/kill per id, then does one
// RF write and/or one X-IF result per committed entry. Option: FIR_XIFU_WB_FWD_EN.
module fir_xifu_wb
  import fir_xifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  fir_xifu_ex2wb_t      ex2wb_i,
  output logic                 wb2ex_ready_o,
  input  logic                 commit_valid_i,
  input  logic [ID_W-1:0]      commit_id_i,
  input  logic                 commit_kill_i,
  output fir_xifu_wb2regfile_t wb2regfile_o,
`ifdef FIR_XIFU_WB_FWD_EN
  output fir_xifu_wb2ex_fwd_t  wb2ex_fwd_o,
`endif
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [ID_W-1:0]      result_id_o,
  output logic [4:0]           result_rd_o,
  output logic                 result_we_o,
  output logic [31:0]          result_data_o
);

  localparam int unsigned NB_IDS = 2 ** ID_W;

  fir_xifu_wb_state_e r_state;
  logic [NB_IDS-1:0]  r_seen;
  logic [NB_IDS-1:0]  r_kill;
  logic               r_res_valid;
  logic [ID_W-1:0]    r_res_id;
  logic [4:0]         r_res_rd;
  logic               r_res_we;
  logic [31:0]        r_res_data;

  fir_xifu_wb_entry_t w_push_entry;
  fir_xifu_wb_entry_t w_head;
  fir_xifu_wb_state_e w_after_pop;
  logic               w_full, w_empty, w_last;
  logic               w_push, w_pop, w_rf_we;
  logic               w_head_seen, w_head_kill;

  assign w_push_entry = '{id:      ex2wb_i.id,
                          rd:      ex2wb_i.rd,
                          write:   ex2wb_i.write,
                          core_rd: ex2wb_i.core_rd,
                          core_we: ex2wb_i.core_we,
                          result:  ex2wb_i.result};
  assign w_push = ex2wb_i.valid & ~w_full;

  fir_xifu_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fir_xifu_wb_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .last_o  (w_last),
    .head_o  (w_head)
  );

  // Ready comes only from the registered count, never from result_ready_i.
  assign wb2ex_ready_o = ~w_full;

  assign w_head_seen = r_seen[w_head.id];
  assign w_head_kill = r_kill[w_head.id];
  assign w_after_pop = (w_last && !w_push) ? WB_IDLE : WB_WAIT_COMMIT;

  always_comb begin
    w_pop   = 1'b0;
    w_rf_we = 1'b0;
    unique case (r_state)
      WB_WAIT_COMMIT: begin
        if (w_head_seen && w_head_kill) begin
          w_pop = 1'b1;
        end else if (w_head_seen && !w_head.core_we) begin
          w_pop   = 1'b1;
          w_rf_we = w_head.write;
        end
      end
      WB_RESULT: begin
        if (result_ready_i) begin
          w_pop   = 1'b1;
          w_rf_we = w_head.write;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wb2regfile_o = '0;
    if (w_rf_we) begin
      wb2regfile_o.write  = 1'b1;
      wb2regfile_o.rd     = w_head.rd;
      wb2regfile_o.result = w_head.result;
    end
  end

`ifdef FIR_XIFU_WB_FWD_EN
  assign wb2ex_fwd_o = '{valid:  wb2regfile_o.write,
                         rd:     wb2regfile_o.rd,
                         result: wb2regfile_o.result};
`endif

  // A commit in the same cycle as a retire of that id is applied last and wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_seen <= '0;
      r_kill <= '0;
    end else begin
      if (w_pop) begin
        r_seen[w_head.id] <= 1'b0;
        r_kill[w_head.id] <= 1'b0;
      end
      if (commit_valid_i) begin
        r_seen[commit_id_i] <= 1'b1;
        r_kill[commit_id_i] <= commit_kill_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= WB_IDLE;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_rd    <= '0;
      r_res_we    <= 1'b0;
      r_res_data  <= '0;
    end else begin
      unique case (r_state)
        WB_IDLE: begin
          if (!w_empty) r_state <= WB_WAIT_COMMIT;
        end
        WB_WAIT_COMMIT: begin
          if (w_head_seen && !w_head_kill && w_head.core_we) begin
            r_state     <= WB_RESULT;
            r_res_valid <= 1'b1;
            r_res_id    <= w_head.id;
            r_res_rd    <= w_head.core_rd;
            r_res_we    <= 1'b1;
            r_res_data  <= w_head.result;
          end else if (w_pop) begin
            r_state <= w_after_pop;
          end
        end
        WB_RESULT: begin
          if (result_ready_i) begin
            r_state     <= w_after_pop;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_rd    <= '0;
            r_res_we    <= 1'b0;
            r_res_data  <= '0;
          end
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  assign result_valid_o = r_res_valid;
  assign result_id_o    = r_res_id;
  assign result_rd_o    = r_res_rd;
  assign result_we_o    = r_res_we;
  assign result_data_o  = r_res_data;

  a_no_double_commit: assert property (@(posedge clk_i) disable iff (rst_i)
    (commit_valid_i && r_seen[commit_id_i]) |-> (w_pop && (w_head.id == commit_id_i)))
    else $error("commit to an id whose slot is already seen");

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Scoreboard bench for fir_xifu_wb: directed scenarios plus randomized traffic; expected
// RF writes / results are queued at commit time and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_fir_xifu_wb;
  import fir_xifu_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  fir_xifu_ex2wb_t      ex2wb_i = '0;
  logic                 wb2ex_ready_o;
  logic                 commit_valid_i = 1'b0;
  logic [ID_W-1:0]      commit_id_i = '0;
  logic                 commit_kill_i = 1'b0;
  fir_xifu_wb2regfile_t wb2regfile_o;
`ifdef FIR_XIFU_WB_FWD_EN
  fir_xifu_wb2ex_fwd_t  wb2ex_fwd_o;
`endif
  logic                 result_valid_o;
  logic                 result_ready_i = 1'b0;
  logic [ID_W-1:0]      result_id_o;
  logic [4:0]           result_rd_o;
  logic                 result_we_o;
  logic [31:0]          result_data_o;

  fir_xifu_wb #(.DEPTH(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ex2wb_i        (ex2wb_i),
    .wb2ex_ready_o  (wb2ex_ready_o),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .wb2regfile_o   (wb2regfile_o),
`ifdef FIR_XIFU_WB_FWD_EN
    .wb2ex_fwd_o    (wb2ex_fwd_o),
`endif
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_rd_o    (result_rd_o),
    .result_we_o    (result_we_o),
    .result_data_o  (result_data_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: committed entries leave in program order; each yields an RF write
  // when write=1 and a result transaction when core_we=1, killed ones yield nothing.
  typedef struct {logic [RD_W-1:0] rd; logic [31:0] data;} rf_exp_t;
  typedef struct {logic [ID_W-1:0] id; logic [4:0] rd; logic [31:0] data;} res_exp_t;
  rf_exp_t  rf_q[$];
  res_exp_t res_q[$];

  task automatic expect_commit(input fir_xifu_ex2wb_t e, input bit kill);
    rf_exp_t  r;
    res_exp_t s;
    if (!kill) begin
      if (e.write) begin
        r.rd = e.rd; r.data = e.result;
        rf_q.push_back(r);
      end
      if (e.core_we) begin
        s.id = e.id; s.rd = e.core_rd; s.data = e.result;
        res_q.push_back(s);
      end
    end
  endtask

  // Monitor
  int unsigned n_rf = 0, rf_cyc_last = 0, rf_cyc_prev = 0;
  logic        prev_hold = 1'b0;
  logic [41:0] p_fields = '0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (wb2regfile_o.write) begin
        n_rf++;
        rf_cyc_prev = rf_cyc_last;
        rf_cyc_last = cyc;
        if (rf_q.size() == 0) begin
          check("rf_unexpected_write", 64'(1), 64'(0));
        end else begin
          rf_exp_t x;
          x = rf_q.pop_front();
          check("rf_rd", 64'(wb2regfile_o.rd), 64'(x.rd));
          check("rf_data", 64'(wb2regfile_o.result), 64'(x.data));
        end
      end else begin
        check("rf_idle_zero", 64'({wb2regfile_o.rd, wb2regfile_o.result}), 64'(0));
      end
      if (prev_hold) begin
        check("res_held_valid", 64'(result_valid_o), 64'(1));
        check("res_held_fields",
              64'({result_id_o, result_rd_o, result_we_o, result_data_o}), 64'(p_fields));
      end
      if (result_valid_o) check("res_we", 64'(result_we_o), 64'(1));
      if (result_valid_o && result_ready_i) begin
        if (res_q.size() == 0) begin
          check("res_unexpected", 64'(1), 64'(0));
        end else begin
          res_exp_t y;
          y = res_q.pop_front();
          check("res_id", 64'(result_id_o), 64'(y.id));
          check("res_rd", 64'(result_rd_o), 64'(y.rd));
          check("res_data", 64'(result_data_o), 64'(y.data));
        end
      end
    end
`ifdef FIR_XIFU_WB_FWD_EN
    check("fwd_copy", 64'(wb2ex_fwd_o), 64'(wb2regfile_o));
`endif
    prev_hold = !rst_i && result_valid_o && !result_ready_i;
    p_fields  = {result_id_o, result_rd_o, result_we_o, result_data_o};
  end

  // Stimulus helpers
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic fir_xifu_ex2wb_t mk(input int id, input int rd, input bit wr,
                                         input int core_rd, input bit core_we,
                                         input logic [31:0] res);
    fir_xifu_ex2wb_t e;
    e.valid   = 1'b0;
    e.id      = ID_W'(id);
    e.rd      = RD_W'(rd);
    e.write   = wr;
    e.core_rd = 5'(core_rd);
    e.core_we = core_we;
    e.result  = res;
    return e;
  endfunction

  task automatic drive_commit(input int id, input bit kill);
    commit_valid_i = 1'b1;
    commit_id_i    = ID_W'(id);
    commit_kill_i  = kill;
    tick(1);
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic push_entry(input fir_xifu_ex2wb_t e);
    bit acc;
    int guard;
    ex2wb_i       = e;
    ex2wb_i.valid = 1'b1;
    guard = 0;
    forever begin
      acc = wb2ex_ready_o;
      tick(1);
      if (acc) break;
      guard++;
      if (guard > 300) begin
        check("push_timeout", 64'(0), 64'(1));
        break;
      end
    end
    ex2wb_i.valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((rf_q.size() != 0 || res_q.size() != 0) && guard < 400) begin
      tick(1);
      guard++;
    end
    tick(3);
    check({name, "_drain"}, 64'(rf_q.size() + res_q.size()), 64'(0));
  endtask

  task automatic wait_valid(input string name);
    int guard;
    guard = 0;
    @(negedge clk_i);
    while (!result_valid_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    check(name, 64'(result_valid_o), 64'(1));
  endtask

  fir_xifu_ex2wb_t txns[64];
  bit              kills[64];
  int              enq_cnt = 0;
  bit              stim_done = 1'b0;
  int unsigned     n0;

  initial begin
    // Reset state
    tick(2);
    @(negedge clk_i);
    check("rst_ready", 64'(wb2ex_ready_o), 64'(1));
    check("rst_res_outs", 64'({result_valid_o, result_id_o, result_rd_o, result_we_o,
                                result_data_o}), 64'(0));
    check("rst_rf", 64'(wb2regfile_o), 64'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    result_ready_i = 1'b1;

    // RF-only entry, committed two cycles after enqueue: one-cycle write after commit
    push_entry(mk(3, 2, 1, 0, 0, 32'hCAFE0001));
    tick(1);
    expect_commit(mk(3, 2, 1, 0, 0, 32'hCAFE0001), 1'b0);
    n0 = n_rf;
    drive_commit(3, 1'b0);
    @(negedge clk_i);
    check("t1_rf_pulse", 64'({wb2regfile_o.write, wb2regfile_o.rd, wb2regfile_o.result}),
          64'({1'b1, 2'd2, 32'hCAFE0001}));
    check("t1_no_result", 64'(result_valid_o), 64'(0));
    @(negedge clk_i);
    check("t1_pulse_one_cycle", 64'(n_rf - n0), 64'(1));
    check("t1_no_result_after", 64'(result_valid_o), 64'(0));
    wait_drain("t1");

    // Commit before EX result; result held while ready low
    result_ready_i = 1'b0;
    expect_commit(mk(5, 0, 0, 10, 1, 32'h1234), 1'b0);
    drive_commit(5, 1'b0);
    push_entry(mk(5, 0, 0, 10, 1, 32'h1234));
    wait_valid("t2_result_valid");
    check("t2_fields", 64'({result_id_o, result_rd_o, result_data_o}),
          64'({4'd5, 5'd10, 32'h1234}));
    repeat (3) begin
      @(negedge clk_i);
      check("t2_held", 64'(result_valid_o), 64'(1));
    end
    @(posedge clk_i); #1;
    result_ready_i = 1'b1;
    tick(1);
    @(negedge clk_i);
    check("t2_released", 64'(result_valid_o), 64'(0));
    wait_drain("t2");

    // Killed entry vanishes
    n0 = n_rf;
    push_entry(mk(7, 1, 1, 3, 1, 32'h77777777));
    drive_commit(7, 1'b1);
    repeat (5) begin
      @(negedge clk_i);
      check("t3_no_result", 64'(result_valid_o), 64'(0));
    end
    check("t3_no_rf", 64'(n_rf - n0), 64'(0));
    check("t3_ready", 64'(wb2ex_ready_o), 64'(1));

    // Fill queue, commit out of order: nothing retires until the head commits
    @(posedge clk_i); #1;
    n0 = n_rf;
    push_entry(mk(1, 1, 1, 0, 0, 32'hAAAA0001));
    push_entry(mk(2, 3, 1, 0, 0, 32'hBBBB0002));
    @(negedge clk_i);
    check("t4_full_not_ready", 64'(wb2ex_ready_o), 64'(0));
    @(posedge clk_i); #1;
    drive_commit(2, 1'b0);
    repeat (4) @(negedge clk_i);
    check("t4_in_order_hold", 64'(n_rf - n0), 64'(0));
    @(posedge clk_i); #1;
    expect_commit(mk(1, 1, 1, 0, 0, 32'hAAAA0001), 1'b0);
    expect_commit(mk(2, 3, 1, 0, 0, 32'hBBBB0002), 1'b0);
    drive_commit(1, 1'b0);
    wait_drain("t4");
    check("t4_two_writes", 64'(n_rf - n0), 64'(2));
    check("t4_back_to_back", 64'(rf_cyc_last - rf_cyc_prev), 64'(1));

    // Reset while a result is pending; stale commit must not retire a reused id
    result_ready_i = 1'b0;
    push_entry(mk(9, 3, 1, 4, 1, 32'hDEAD0009));
    drive_commit(9, 1'b0);
    drive_commit(11, 1'b0);
    wait_valid("t5_pending_valid");
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    tick(1);
    @(negedge clk_i);
    check("t5_rst_res_outs", 64'({result_valid_o, result_id_o, result_rd_o, result_we_o,
                                   result_data_o}), 64'(0));
    check("t5_rst_rf", 64'(wb2regfile_o), 64'(0));
    check("t5_rst_ready", 64'(wb2ex_ready_o), 64'(1));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    result_ready_i = 1'b1;
    n0 = n_rf;
    push_entry(mk(11, 2, 1, 0, 0, 32'h0B0B0B0B));
    repeat (6) @(negedge clk_i);
    check("t5_stale_commit_ignored", 64'(n_rf - n0), 64'(0));
    @(posedge clk_i); #1;
    expect_commit(mk(11, 2, 1, 0, 0, 32'h0B0B0B0B), 1'b0);
    drive_commit(11, 1'b0);
    wait_drain("t5");
    check("t5_retired_after_commit", 64'(n_rf - n0), 64'(1));

    // Randomized traffic: ids reused cyclically, commits may lead or lag enqueue
    for (int k = 0; k < 64; k++) begin
      txns[k] = mk(k % 16, int'($urandom_range(0, NB_REGS - 1)), 1'($urandom),
                   int'($urandom_range(0, 31)), 1'($urandom), $urandom);
      kills[k] = ($urandom_range(0, 3) == 0);
    end
    fork
      begin
        fork
          begin
            for (int k = 0; k < 64; k++) begin
              tick(int'($urandom_range(0, 2)));
              push_entry(txns[k]);
              enq_cnt++;
            end
          end
          begin
            for (int k = 0; k < 64; k++) begin
              int guard;
              guard = 0;
              while (enq_cnt + 12 < k && guard < 2000) begin
                tick(1);
                guard++;
              end
              tick(int'($urandom_range(0, 3)));
              expect_commit(txns[k], kills[k]);
              drive_commit(k % 16, kills[k]);
            end
          end
        join
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          result_ready_i = ($urandom_range(0, 2) != 0);
          tick(1);
        end
      end
    join
    result_ready_i = 1'b1;
    wait_drain("rand");
    @(negedge clk_i);
    check("end_idle", 64'({wb2ex_ready_o, result_valid_o}), 64'({1'b1, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
